// File: rtl/text_cell_gen.sv
// Maps raster pixels onto a fixed character window, holds the text buffer
// and drives the blinking cursor flag, two clocks from pixel to output.
module text_cell_gen #(
    parameter int COLS         = 16,
    parameter int ROWS         = 4,
    parameter int X0           = 64,
    parameter int Y0           = 32,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_FRAMES = 30,
    localparam int AW          = $clog2(COLS * ROWS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          de,
    input  logic [10:0]   pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          cur_set,
    input  logic [AW-1:0] cur_addr,
    input  logic          cursor_en,
    output logic [7:0]    char_code,
    output logic [2:0]    char_h,
    output logic [2:0]    char_v,
    output logic          in_window,
    output logic          invert
);

    localparam int CW = $clog2(COLS);
    localparam int FW = $clog2(BLINK_FRAMES) + 1;
    localparam int SH = SCALE_LOG2 + 3;
    localparam logic [12:0] WPIX = 13'((COLS * 8) << SCALE_LOG2);
    localparam logic [11:0] HPIX = 12'((ROWS * 8) << SCALE_LOG2);

    logic [11:0]   rel_x;
    logic [10:0]   rel_y;
    logic [10:0]   col_w;
    logic [9:0]    row_w;
    logic [AW-1:0] cell_w;
    logic          win_w;
    logic          frame_start;

    logic          s1_win;
    logic          s1_match;
    logic [2:0]    s1_h;
    logic [2:0]    s1_v;
    logic [AW-1:0] s1_cell;

    logic [7:0]    mem [COLS*ROWS];
    logic [7:0]    rd_q;

    logic [AW-1:0] cur_pos;
    logic [FW-1:0] fcnt;
    logic          blink_phase;

    always_comb begin
        rel_x  = {1'b0, pixel_x} - 12'(X0);
        rel_y  = {1'b0, pixel_y} - 11'(Y0);
        win_w  = de
               & ~rel_x[11] & ({2'b0, rel_x[10:0]} < WPIX)
               & ~rel_y[10] & ({2'b0, rel_y[9:0]} < HPIX);
        col_w  = rel_x[10:0] >> SH;
        row_w  = rel_y[9:0] >> SH;
        // Column is below COLS whenever the pixel is inside the window.
        cell_w = AW'({row_w, {CW{1'b0}}}) | AW'(col_w);
        frame_start = de & (pixel_x == 11'd0) & (pixel_y == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_win   <= 1'b0;
            s1_match <= 1'b0;
            s1_h     <= 3'd0;
            s1_v     <= 3'd0;
            s1_cell  <= '0;
        end else begin
            s1_win   <= win_w;
            s1_match <= (cell_w == cur_pos);
            s1_h     <= win_w ? rel_x[SCALE_LOG2 +: 3] : 3'd0;
            s1_v     <= win_w ? rel_y[SCALE_LOG2 +: 3] : 3'd0;
            s1_cell  <= cell_w;
        end
    end

    // Buffer is not reset so it maps onto block RAM; read-first on collision.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_q <= mem[s1_cell];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_window <= 1'b0;
            char_h    <= 3'd0;
            char_v    <= 3'd0;
            invert    <= 1'b0;
        end else begin
            in_window <= s1_win;
            char_h    <= s1_h;
            char_v    <= s1_v;
            invert    <= s1_win & s1_match & cursor_en & blink_phase;
        end
    end

    assign char_code = rd_q & {8{in_window}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_pos     <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (cur_set) begin
            cur_pos     <= cur_addr;
            fcnt        <= '0;
            blink_phase <= 1'b1;
        end else if (frame_start) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt        <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_text_cell_gen.sv
// Directed bench for text_cell_gen: geometry, scaling, read-first buffer,
// cursor blink and mid-line reset.
module tb_text_cell_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        de;
    logic [10:0] pixel_x;
    logic [9:0]  pixel_y;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        cur_set;
    logic [5:0]  cur_addr;
    logic        cursor_en;

    logic [7:0]  code0, code1;
    logic [2:0]  h0, h1, v0, v1;
    logic        win0, win1, inv0, inv1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    text_cell_gen #(.SCALE_LOG2(0), .BLINK_FRAMES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .de(de),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_set(cur_set), .cur_addr(cur_addr), .cursor_en(cursor_en),
        .char_code(code0), .char_h(h0), .char_v(v0),
        .in_window(win0), .invert(inv0)
    );

    text_cell_gen #(.SCALE_LOG2(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .de(de),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_set(cur_set), .cur_addr(cur_addr), .cursor_en(cursor_en),
        .char_code(code1), .char_h(h1), .char_v(v1),
        .in_window(win1), .invert(inv1)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic d);
        pixel_x = 11'(x);
        pixel_y = 10'(y);
        de      = d;
        tick();
        tick();
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 6'(a);
        wr_data = 8'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic fstart();
        pixel_x = 11'd0;
        pixel_y = 10'd0;
        de      = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; de = 1'b0; pixel_x = '0; pixel_y = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cur_set = 1'b0; cur_addr = '0; cursor_en = 1'b0;
        repeat (3) tick();
        chk("rst_code", code0, 8'h00);
        chk("rst_win", {7'd0, win0}, 8'd0);
        chk("rst_inv", {7'd0, inv0}, 8'd0);
        chk("rst_h", {5'd0, h0}, 8'd0);
        chk("rst_win1", {7'd0, win1}, 8'd0);
        rst_n = 1'b1;

        wr(0, 8'h41);
        wr(17, 8'h42);
        wr(63, 8'h7E);
        wr(1, 8'h31);

        pix(64, 32, 1'b1);
        chk("t1a_code", code0, 8'h41);
        chk("t1a_h", {5'd0, h0}, 8'd0);
        chk("t1a_v", {5'd0, v0}, 8'd0);
        chk("t1a_win", {7'd0, win0}, 8'd1);
        pix(79, 43, 1'b1);
        chk("t1b_code", code0, 8'h42);
        chk("t1b_h", {5'd0, h0}, 8'd7);
        chk("t1b_v", {5'd0, v0}, 8'd3);

        pix(63, 32, 1'b1);
        chk("left_win", {7'd0, win0}, 8'd0);
        chk("left_code", code0, 8'h00);
        pix(192, 32, 1'b1);
        chk("right_win", {7'd0, win0}, 8'd0);
        chk("right_code", code0, 8'h00);
        pix(64, 31, 1'b1);
        chk("top_win", {7'd0, win0}, 8'd0);
        chk("top_h", {5'd0, h0}, 8'd0);
        pix(64, 64, 1'b1);
        chk("bot_win", {7'd0, win0}, 8'd0);
        chk("bot_code", code0, 8'h00);
        pix(191, 63, 1'b1);
        chk("last_win", {7'd0, win0}, 8'd1);
        chk("last_code", code0, 8'h7E);
        chk("last_h", {5'd0, h0}, 8'd7);
        chk("last_v", {5'd0, v0}, 8'd7);
        pix(100, 40, 1'b0);
        chk("de0_win", {7'd0, win0}, 8'd0);
        chk("de0_code", code0, 8'h00);

        pix(83, 37, 1'b1);
        chk("s1_h", {5'd0, h1}, 8'd1);
        chk("s1_v", {5'd0, v1}, 8'd2);
        chk("s1_code", code1, 8'h31);
        chk("s1_win", {7'd0, win1}, 8'd1);
        pix(319, 32, 1'b1);
        chk("s1_edge_in", {7'd0, win1}, 8'd1);
        pix(320, 32, 1'b1);
        chk("s1_edge_out", {7'd0, win1}, 8'd0);

        pixel_x = 11'd64; pixel_y = 10'd32; de = 1'b1;
        tick();
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        chk("rf_old", code0, 8'h41);
        tick();
        chk("rf_new", code0, 8'h55);

        cursor_en = 1'b1;
        cur_addr = 6'd5; cur_set = 1'b1;
        tick();
        cur_set = 1'b0;
        pix(104, 32, 1'b1);
        chk("blink_f0", {7'd0, inv0}, 8'd1);
        pix(112, 32, 1'b1);
        chk("cell6_f0", {7'd0, inv0}, 8'd0);
        fstart();
        pix(104, 32, 1'b1);
        chk("blink_f1", {7'd0, inv0}, 8'd1);
        fstart();
        pix(104, 32, 1'b1);
        chk("blink_f2", {7'd0, inv0}, 8'd0);
        fstart();
        pix(104, 32, 1'b1);
        chk("blink_f3", {7'd0, inv0}, 8'd0);
        pix(112, 32, 1'b1);
        chk("cell6_f3", {7'd0, inv0}, 8'd0);
        fstart();
        pix(104, 32, 1'b1);
        chk("blink_f4", {7'd0, inv0}, 8'd1);
        fstart();
        pix(104, 32, 1'b1);
        chk("blink_f5", {7'd0, inv0}, 8'd1);
        pix(112, 32, 1'b1);
        chk("cell6_f5", {7'd0, inv0}, 8'd0);
        cursor_en = 1'b0;
        pix(104, 32, 1'b1);
        chk("cur_off", {7'd0, inv0}, 8'd0);
        cursor_en = 1'b1;
        pix(104, 32, 1'b1);
        chk("cur_on", {7'd0, inv0}, 8'd1);

        pixel_x = 11'd79; pixel_y = 10'd43;
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_code", code0, 8'h00);
        chk("mid_h", {5'd0, h0}, 8'd0);
        chk("mid_v", {5'd0, v0}, 8'd0);
        chk("mid_win", {7'd0, win0}, 8'd0);
        chk("mid_inv", {7'd0, inv0}, 8'd0);
        rst_n = 1'b1;
        pix(64, 32, 1'b1);
        chk("post_code0", code0, 8'h55);
        chk("post_win", {7'd0, win0}, 8'd1);
        chk("post_inv", {7'd0, inv0}, 8'd0);
        pix(79, 43, 1'b1);
        chk("post_code17", code0, 8'h42);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_cell_gen.md
Name: text_cell_gen

Overview:
- Upstream stage of the glyph-dot lookup in the text overlay path.
- Takes the raster pixel coordinates from the video timing generator and maps them onto a fixed character window.
- Holds the on-screen text buffer and manages a blinking cursor.
- Outputs per pixel: character code (to the font ROM), glyph column/row (char_h/char_v), window-valid and cursor-invert flags, all pipeline-aligned.

Parameters:
- COLS, 16, characters per text row; power of two, 2..64.
- ROWS, 4, text rows; power of two, 1..32.
- X0, 64, window left edge, in pixels.
- Y0, 32, window top edge, in pixels.
- SCALE_LOG2, 0, glyph magnification = 2^SCALE_LOG2 (0..2).
- BLINK_FRAMES, 30, frames per cursor blink half-period; must be ≥1.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous reset, active-low; one clock; all state on rising edge of clk.
- de  in  1  active-video enable, aligned with pixel_x/pixel_y.
- pixel_x  in  11  current pixel column.
- pixel_y  in  10  current pixel line.
- wr_en  in  1  text buffer write strobe.
- wr_addr  in  AW  write cell index (row*COLS+col); AW = log2(COLS*ROWS).
- wr_data  in  8  character code to store.
- cur_set  in  1  load cursor position.
- cur_addr  in  AW  new cursor cell index.
- cursor_en  in  1  cursor display enable.
- char_code  out  8  code of the cell under the pixel.
- char_h  out  3  glyph column 0..7.
- char_v  out  3  glyph row 0..7.
- in_window  out  1  pixel lies inside the text window and de was high.
- invert  out  1  pixel lies in the cursor cell during the visible blink phase.

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0; cursor position = 0; frame counter = 0; blink_phase = 0; pipeline flags cleared. Text buffer contents are not reset; they keep their value.
- Geometry:
  - rel_x = pixel_x − X0, rel_y = pixel_y − Y0, computed 12/11-bit signed.
  - Inside the window iff de=1, rel_x ≥ 0, rel_x < COLS·8·2^S, rel_y ≥ 0 and rel_y < ROWS·8·2^S, where S = SCALE_LOG2.
  - char_h = rel_x[S+2:S]; char_v = rel_y[S+2:S].
  - col = rel_x >> (S+3); row = rel_y >> (S+3); cell = {row, col}.
  - No dividers or multipliers.
- Pipeline, fixed latency 2 clocks from pixel_x/pixel_y/de to every output:
  - Stage 1 registers rel fields, window flag, cell index and cursor-match (cell == cursor position).
  - Stage 2 is the synchronous buffer read; char_code is valid at stage 2. char_h, char_v, in_window and invert are delayed to match.
- Outside the window: in_window=0, invert=0, char_h=char_v=0, char_code=0.
- Text buffer:
  - COLS·ROWS × 8 single-write, single-read synchronous RAM; block-RAM inferable.
  - Write on wr_en at the clk edge.
  - Read and write to the same cell in the same cycle is read-first: the old code is output and the new code is visible from the next read.
- Cursor:
  - cur_set loads cur_addr at the edge and resets blink_phase to 1 (visible) and the frame counter to 0.
  - A frame start is de=1 with pixel_x=0 and pixel_y=0.
  - On each frame start the frame counter increments. At BLINK_FRAMES−1 it wraps to 0 and toggles blink_phase.
  - If cur_set coincides with a frame start, cur_set wins.
  - invert = in_window & cursor_en & blink_phase & cursor-match.
- Mid-frame reset: outputs go 0 on the next edge. Valid outputs resume 2 clocks after rst_n returns high.

Test Plan:
1. After reset, write 0x41 to cell 0 and 0x42 to cell 17. Drive pixel (64,32) → two clocks later char_code=0x41, char_h=0, char_v=0, in_window=1. Drive pixel (79,43) → char_code=0x42, char_h=7, char_v=3.
2. Drive window edges (63,32), (192,32), (64,31), (64,64) → in_window=0, char_code=0. Drive (191,63) → in_window=1, cell 63, char_h=7, char_v=7. Drive (100,40) with de=0 → in_window=0.
3. With SCALE_LOG2=1, drive pixel (64+19, 32+5) → char_h=1, char_v=2, cell 1. Drive (64+255, 32) → in_window=1. Drive (64+256, 32) → in_window=0.
4. Hold pixel (64,32) and write 0x55 to cell 0 in the same cycle the read is issued → old code returned. The next read returns 0x55.
5. cursor_en=1, cur_set to cell 5, BLINK_FRAMES=2. Scan cell 5 → invert=1 for frames 0–1, 0 for frames 2–3, 1 for frames 4–5. Cell 6 never inverts. With cursor_en=0, invert is always 0.
6. Assert rst_n low mid-line → all outputs 0 the next cycle and blink_phase=0. Buffer codes written earlier still read back after release.
